// File: rtl/sccb_write_arbiter_if.sv
// Bundle of the requester-side and write-engine-side signals of the SCCB write arbiter.
// The arbiter connects through the slave modport; the requesters and engine through master.
interface sccb_write_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_valid_in;
    logic [24*NUM_REQ-1:0] req_regpair_in;
    logic [NUM_REQ-1:0]    req_ready_out;
    logic [NUM_REQ-1:0]    req_done_out;
    logic [NUM_REQ-1:0]    req_err_out;
    logic                  wr_valid_out;
    logic [23:0]           wr_regpair_out;
    logic                  wr_ready_in;
    logic                  wr_done_in;
    logic                  wr_missed_ack_in;
    logic                  busy_out;

    modport slave (
        input  req_valid_in, req_regpair_in, wr_ready_in, wr_done_in, wr_missed_ack_in,
        output req_ready_out, req_done_out, req_err_out, wr_valid_out, wr_regpair_out, busy_out
    );

    modport master (
        output req_valid_in, req_regpair_in, wr_ready_in, wr_done_in, wr_missed_ack_in,
        input  req_ready_out, req_done_out, req_err_out, wr_valid_out, wr_regpair_out, busy_out
    );
endinterface

// File: rtl/sccb_write_arbiter.sv
// Round-robin arbiter sharing one SCCB register-write engine among NUM_REQ requesters.
// Holds off after reset for camera power-up, spaces writes by a fixed gap, retries
// NACKed writes up to MAX_RETRY times and reports done/error per write.
module sccb_write_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int STARTUP_CYCLES = 20000,
    parameter int GAP_CYCLES     = 100,
    parameter int MAX_RETRY      = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    sccb_write_arbiter_if.slave  bus
);

    localparam int CNT_MAX = (STARTUP_CYCLES > GAP_CYCLES) ? STARTUP_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int SUM_W   = IDX_W + 1;

    // A zero-length hold-off or gap still occupies its state for one cycle.
    localparam logic [CNT_W-1:0]   STARTUP_LAST = CNT_W'((STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1);
    localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE      = IDX_W'(1);

    typedef enum logic [2:0] {
        S_STARTUP,
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_RETRY_GAP,
        S_COMPLETE,
        S_GAP
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic [23:0]          r_regpair;
    logic [RETRY_W-1:0]   r_retry;
    logic                 r_err;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     w_ptr_nxt;
    logic [IDX_W-1:0]     w_owner_nxt;
    logic [23:0]          w_regpair_nxt;
    logic [RETRY_W-1:0]   w_retry_nxt;
    logic                 w_err_nxt;

    logic [2*NUM_REQ-1:0] w_rot;
    logic [SUM_W-1:0]     w_sum;
    logic                 w_found;
    logic [IDX_W-1:0]     w_winner;
    logic [23:0]          w_sel_pair;
    logic [NUM_REQ-1:0]   w_owner_oh;

    // Round-robin pick: rotate the request vector so the pointer sits at bit 0, take the first set bit.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_rot      = {bus.req_valid_in, bus.req_valid_in} >> r_ptr;
        w_found    = 1'b0;
        w_sum      = '0;
        w_winner   = '0;
        w_sel_pair = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + SUM_W'(k);
                if (w_sum >= SUM_W'(NUM_REQ)) begin
                    w_sum = w_sum - SUM_W'(NUM_REQ);
                end
                w_winner = w_sum[IDX_W-1:0];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_sel_pair = bus.req_regpair_in[24*i +: 24];
            end
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ptr_nxt     = r_ptr;
        w_owner_nxt   = r_owner;
        w_regpair_nxt = r_regpair;
        w_retry_nxt   = r_retry;
        w_err_nxt     = r_err;

        w_owner_oh         = NUM_REQ'(1) << r_owner;
        bus.req_ready_out  = '0;
        bus.req_done_out   = '0;
        bus.req_err_out    = '0;
        bus.wr_valid_out   = 1'b0;
        bus.wr_regpair_out = '0;
        bus.busy_out       = (r_state != S_IDLE);

        case (r_state)
            S_STARTUP: begin
                if (r_cnt == STARTUP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            S_IDLE: begin
                if (w_found) begin
                    bus.req_ready_out = NUM_REQ'(1) << w_winner;
                    w_owner_nxt       = w_winner;
                    w_regpair_nxt     = w_sel_pair;
                    w_retry_nxt       = '0;
                    w_err_nxt         = 1'b0;
                    w_ptr_nxt         = (w_winner == IDX_LAST) ? '0 : w_winner + IDX_ONE;
                    // An all-zero regpair is a no-op write: acknowledge it without touching the bus.
                    w_state_nxt       = (w_sel_pair == 24'h000000) ? S_COMPLETE : S_ISSUE;
                end
            end

            S_ISSUE: begin
                bus.wr_valid_out   = 1'b1;
                bus.wr_regpair_out = r_regpair;
                if (bus.wr_ready_in) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                if (bus.wr_done_in) begin
                    if (!bus.wr_missed_ack_in) begin
                        w_state_nxt = S_COMPLETE;
                    end else if (r_retry < RETRY_MAX) begin
                        w_retry_nxt = r_retry + RETRY_ONE;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_RETRY_GAP;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_COMPLETE;
                    end
                end
            end

            S_RETRY_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            S_COMPLETE: begin
                bus.req_done_out = w_owner_oh;
                bus.req_err_out  = r_err ? w_owner_oh : '0;
                w_err_nxt        = 1'b0;
                w_cnt_nxt        = '0;
                w_state_nxt      = S_GAP;
            end

            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_STARTUP;
            end
        endcase
    end

    // State and datapath registers; synchronous active-low reset drops any write in flight.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_in) begin
            r_state   <= S_STARTUP;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_regpair <= '0;
            r_retry   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_regpair <= w_regpair_nxt;
            r_retry   <= w_retry_nxt;
            r_err     <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// Directed, scoreboard-checked bench for sccb_write_arbiter: startup hold-off,
// round-robin order, retry success/exhaustion, zero regpair and reset mid-write.
module tb_sccb_write_arbiter;

    localparam int N       = 3;
    localparam int STARTUP = 50;
    localparam int GAP_C   = 5;
    localparam int RETRY   = 2;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   cyc_cnt = 0;

    int errors = 0;
    int checks = 0;

    // Scoreboard queues, filled as stimulus is driven, drained by the monitor.
    int          exp_grant_q[$];
    logic [23:0] exp_wr_q[$];
    logic [5:0]  exp_done_q[$];   // {done[2:0], err[2:0]}
    int          hs_cyc[$];
    logic        bad_onehot   = 1'b0;
    logic        bad_idle_pair = 1'b0;

    sccb_write_arbiter_if #(.NUM_REQ(N)) bus ();

    sccb_write_arbiter #(
        .NUM_REQ        (N),
        .STARTUP_CYCLES (STARTUP),
        .GAP_CYCLES     (GAP_C),
        .MAX_RETRY      (RETRY)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge (the drive window).
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    // Monitor: compare DUT outputs against the scoreboard on the falling edge.
    always @(negedge clk_in) begin : monitor
        int          g;
        logic [23:0] rp;
        logic [5:0]  de;
        if (rst_in) begin
            if ($countones(bus.req_ready_out) > 1) bad_onehot = 1'b1;
            if (!bus.wr_valid_out && bus.wr_regpair_out != 24'h0) bad_idle_pair = 1'b1;
            if (bus.req_ready_out != '0) begin
                if (exp_grant_q.size() == 0) begin
                    check("unexpected_grant", 64'(bus.req_ready_out), 64'h0);
                end else begin
                    g = exp_grant_q.pop_front();
                    check("grant", 64'(bus.req_ready_out), 64'(N'(1) << g));
                end
            end
            if (bus.wr_valid_out && bus.wr_ready_in) begin
                hs_cyc.push_back(cyc_cnt);
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_write", 64'(bus.wr_regpair_out), 64'hdead);
                end else begin
                    rp = exp_wr_q.pop_front();
                    check("wr_regpair", 64'(bus.wr_regpair_out), 64'(rp));
                end
            end
            if (bus.req_done_out != '0 || bus.req_err_out != '0) begin
                if (exp_done_q.size() == 0) begin
                    check("unexpected_done", 64'({bus.req_done_out, bus.req_err_out}), 64'h0);
                end else begin
                    de = exp_done_q.pop_front();
                    check("done_err", 64'({bus.req_done_out, bus.req_err_out}), 64'(de));
                end
            end
        end
    end

    // Release reset with one requester valid and count cycles to its accept.
    task automatic startup_accept(input int idx, input logic [23:0] rp, input logic stray_done);
        int n = 1;
        bus.req_regpair_in[24*idx +: 24] = rp;
        bus.req_valid_in[idx] = 1'b1;
        bus.wr_done_in        = stray_done;
        bus.wr_missed_ack_in  = stray_done;
        rst_in = 1'b1;
        #1;
        while (!bus.req_ready_out[idx] && n < 200) begin
            cyc();
            n++;
            bus.wr_done_in       = 1'b0;
            bus.wr_missed_ack_in = 1'b0;
        end
        check(stray_done ? "restart_accept_cycle" : "startup_accept_cycle", 64'(n), 64'(STARTUP + 1));
        cyc();
        bus.req_valid_in[idx] = 1'b0;
        check("issue_latency", 64'({bus.wr_valid_out, bus.wr_regpair_out}), 64'({1'b1, rp}));
    endtask

    // Raise one request and hold it until accepted.
    task automatic request(input int idx, input logic [23:0] rp);
        int n = 0;
        bus.req_regpair_in[24*idx +: 24] = rp;
        bus.req_valid_in[idx] = 1'b1;
        #1;
        while (!bus.req_ready_out[idx] && n < 500) begin
            cyc();
            n++;
        end
        check("accept", 64'(bus.req_ready_out[idx]), 64'h1);
        cyc();
        bus.req_valid_in[idx] = 1'b0;
    endtask

    // Engine model: take the regpair, then pulse done `delay` cycles after ready.
    task automatic engine(input logic nack, input int delay);
        int n = 0;
        while (!bus.wr_valid_out && n < 500) begin
            cyc();
            n++;
        end
        check("engine_sees_valid", 64'(bus.wr_valid_out), 64'h1);
        bus.wr_ready_in = 1'b1;
        cyc();
        bus.wr_ready_in = 1'b0;
        repeat (delay - 1) cyc();
        bus.wr_done_in       = 1'b1;
        bus.wr_missed_ack_in = nack;
        cyc();
        bus.wr_done_in       = 1'b0;
        bus.wr_missed_ack_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy_out && n < 500) begin
            cyc();
            n++;
        end
        check(tag, 64'(bus.busy_out), 64'h0);
    endtask

    initial begin
        int min_diff;
        bus.req_valid_in     = '0;
        bus.req_regpair_in   = '0;
        bus.wr_ready_in      = 1'b0;
        bus.wr_done_in       = 1'b0;
        bus.wr_missed_ack_in = 1'b0;

        // Reset state.
        repeat (3) cyc();
        check("reset_busy", 64'(bus.busy_out), 64'h1);
        check("reset_outputs", 64'({bus.req_ready_out, bus.req_done_out, bus.req_err_out,
                                    bus.wr_valid_out, bus.wr_regpair_out}), 64'h0);

        // Startup hold-off, then a clean write by requester 0.
        exp_grant_q.push_back(0);
        exp_wr_q.push_back(24'h300882);
        exp_done_q.push_back({3'b001, 3'b000});
        startup_accept(0, 24'h300882, 1'b0);
        engine(1'b0, 3);
        wait_idle("idle_after_startup");

        // Zero regpair from requester 2: completes without an engine write.
        hs_cyc.delete();
        exp_grant_q.push_back(2);
        exp_done_q.push_back({3'b100, 3'b000});
        request(2, 24'h000000);
        check("zero_done_next_cycle", 64'({bus.req_done_out, bus.req_err_out, bus.wr_valid_out}),
              64'({3'b100, 3'b000, 1'b0}));
        wait_idle("idle_after_zero");
        check("zero_no_engine_write", 64'(hs_cyc.size()), 64'h0);

        // Round-robin with all three requesters permanently valid.
        hs_cyc.delete();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                exp_grant_q.push_back(i);
                exp_wr_q.push_back(24'h100000 * (i + 1) + 24'(r + 1));
                exp_done_q.push_back({3'(N'(1) << i), 3'b000});
            end
        end
        bus.req_regpair_in = {24'h300001, 24'h200001, 24'h100001};
        bus.req_valid_in   = 3'b111;
        for (int i = 0; i < 2 * N; i++) begin
            if (i == N) bus.req_regpair_in = {24'h300002, 24'h200002, 24'h100002};
            engine(1'b0, 10);
        end
        bus.req_valid_in = 3'b000;
        wait_idle("idle_after_rr");
        min_diff = 1000;
        for (int i = 1; i < hs_cyc.size(); i++) begin
            if (hs_cyc[i] - hs_cyc[i-1] < min_diff) min_diff = hs_cyc[i] - hs_cyc[i-1];
        end
        check("rr_write_count", 64'(hs_cyc.size()), 64'(2 * N));
        check("rr_spacing", 64'(min_diff >= GAP_C + 3 + 10), 64'h1);

        // Retry that succeeds on the second attempt.
        hs_cyc.delete();
        exp_grant_q.push_back(1);
        exp_wr_q.push_back(24'h350300);
        exp_wr_q.push_back(24'h350300);
        exp_done_q.push_back({3'b010, 3'b000});
        request(1, 24'h350300);
        engine(1'b1, 3);
        engine(1'b0, 3);
        wait_idle("idle_after_retry");
        check("retry_write_count", 64'(hs_cyc.size()), 64'h2);
        if (hs_cyc.size() == 2) begin
            check("retry_spacing", 64'((hs_cyc[1] - hs_cyc[0]) >= GAP_C + 4), 64'h1);
        end

        // Retry exhaustion: every attempt NACKed.
        hs_cyc.delete();
        exp_grant_q.push_back(1);
        for (int i = 0; i <= RETRY; i++) exp_wr_q.push_back(24'habcdef);
        exp_done_q.push_back({3'b010, 3'b010});
        request(1, 24'habcdef);
        for (int i = 0; i <= RETRY; i++) engine(1'b1, 3);
        wait_idle("idle_after_exhaust");
        check("exhaust_write_count", 64'(hs_cyc.size()), 64'(RETRY + 1));

        // Reset while waiting for the engine: silent drop, then a fresh startup.
        exp_grant_q.push_back(0);
        exp_wr_q.push_back(24'h123456);
        request(0, 24'h123456);
        bus.wr_ready_in = 1'b1;
        cyc();
        bus.wr_ready_in = 1'b0;
        repeat (2) cyc();
        rst_in = 1'b0;
        cyc();
        check("rstmid_busy", 64'(bus.busy_out), 64'h1);
        check("rstmid_engine_idle", 64'({bus.wr_valid_out, bus.wr_regpair_out}), 64'h0);
        check("rstmid_no_pulse", 64'({bus.req_done_out, bus.req_err_out}), 64'h0);
        exp_grant_q.push_back(2);
        exp_wr_q.push_back(24'h777777);
        exp_done_q.push_back({3'b100, 3'b000});
        startup_accept(2, 24'h777777, 1'b1);
        engine(1'b0, 2);
        wait_idle("idle_after_restart");

        // Everything expected was seen, and nothing malformed appeared.
        repeat (2) cyc();
        check("grant_queue_drained", 64'(exp_grant_q.size()), 64'h0);
        check("write_queue_drained", 64'(exp_wr_q.size()), 64'h0);
        check("done_queue_drained", 64'(exp_done_q.size()), 64'h0);
        check("ready_onehot", 64'(bad_onehot), 64'h0);
        check("regpair_zero_when_invalid", 64'(bad_idle_pair), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
